// File: rtl/array_allocator_pkg.sv
// Shared types for the heap-array handle allocator: handle width, op codes and
// the reasons an op can be rejected.
package array_alloc_pkg;

   localparam int HANDLE_W        = 12;
   localparam int NREQ_DEFAULT    = 4;
   localparam int NARRAYS_DEFAULT = 16;

   typedef logic [HANDLE_W-1:0] handle_t;

   typedef enum logic {
      OP_ALLOC = 1'b0,
      OP_FREE  = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_EXHAUSTED,
      ERR_BAD_HANDLE,
      ERR_DOUBLE_FREE
   } err_e;

endpackage

// File: rtl/array_allocator_if.sv
// Requester-side bus of the array allocator: request vectors in, registered
// response and bookkeeping outputs back.
interface array_allocator_if #(
   parameter int NReq = 4,
   parameter int HW   = 12
);

   logic [NReq-1:0]    req;
   logic [NReq-1:0]    req_free;
   logic [NReq*HW-1:0] req_handle;
   logic [NReq-1:0]    ack;
   logic [HW-1:0]      ack_handle;
   logic               ack_err;
   logic               clr_valid;
   logic [HW-1:0]      clr_handle;
   logic [HW:0]        live_count;
   logic [HW:0]        high_water;

   modport master (
      output req, req_free, req_handle,
      input  ack, ack_handle, ack_err, clr_valid, clr_handle, live_count, high_water
   );

   modport slave (
      input  req, req_free, req_handle,
      output ack, ack_handle, ack_err, clr_valid, clr_handle, live_count, high_water
   );

endinterface

// File: rtl/array_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
   parameter int NReq = 4,
   parameter int PW   = (NReq > 1) ? $clog2(NReq) : 1
) (
   input  logic [NReq-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NReq-1:0] grant,
   output logic [PW-1:0]   idx,
   output logic            valid
);

   // Scan NReq positions starting at ptr, wrapping; only the first hit counts.
   always_comb begin
      logic [PW-1:0] cand;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = 0; k < NReq; k++) begin
         cand = PW'((int'(ptr) + k) % NReq);
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/array_allocator.sv
// Arbitrated array-handle allocator: recycles freed handles LIFO before fresh
// ones and strobes a size-table clear on every successful alloc or free.
module array_allocator
   import array_alloc_pkg::*;
#(
   parameter int NReq    = NREQ_DEFAULT,
   parameter int NArrays = NARRAYS_DEFAULT,
   parameter int HW      = HANDLE_W
) (
   input logic               clock,
   input logic               reset,
   array_allocator_if.slave  bus
);

   localparam int PW = (NReq > 1) ? $clog2(NReq) : 1;
   localparam int IW = (NArrays > 1) ? $clog2(NArrays) : 1;
   localparam int CW = $clog2(NArrays + 1);
   localparam logic [CW-1:0] NARR_C   = CW'(NArrays);
   localparam logic [HW:0]   NARR_H   = (HW+1)'(NArrays);
   localparam logic [PW-1:0] LAST_REQ = PW'(NReq - 1);

   logic [HW-1:0]   stack_mem [NArrays];
   logic [CW-1:0]   stack_top;
   logic [CW-1:0]   fresh;
   logic [NArrays-1:0] in_use;
   logic [PW-1:0]   rr_ptr;

   logic [NReq-1:0] ack_q;
   logic [HW-1:0]   ack_handle_q;
   logic            ack_err_q;
   logic            clr_valid_q;
   logic [HW-1:0]   clr_handle_q;
   logic [HW:0]     live_q;
   logic [HW:0]     high_q;

   logic [NReq-1:0] eligible;
   logic [NReq-1:0] grant;
   logic [PW-1:0]   win;
   logic            win_valid;

   // A requester seeing its ack this cycle may still hold req; it must not win again yet.
   assign eligible = bus.req & ~ack_q;

   rr_arbiter #(
      .NReq (NReq),
      .PW   (PW)
   ) u_arb (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win),
      .valid (win_valid)
   );

   op_e           op;
   err_e          err;
   logic [HW-1:0] free_handle;
   logic [HW-1:0] pop_handle;
   logic [HW-1:0] res_handle;
   logic          do_pop;
   logic          do_fresh;
   logic          do_push;
   logic          success;
   logic [HW:0]   live_next;

   // Decide the winner's op outcome; the stack is always preferred over fresh handles.
   always_comb begin
      op          = bus.req_free[win] ? OP_FREE : OP_ALLOC;
      free_handle = bus.req_handle[win*HW +: HW];
      pop_handle  = stack_mem[IW'(stack_top - 1'b1)];
      err         = ERR_NONE;
      res_handle  = '0;
      do_pop      = 1'b0;
      do_fresh    = 1'b0;
      do_push     = 1'b0;
      live_next   = live_q;
      if (win_valid) begin
         if (op == OP_ALLOC) begin
            if (stack_top != '0) begin
               do_pop     = 1'b1;
               res_handle = pop_handle;
               live_next  = live_q + 1'b1;
            end else if (fresh < NARR_C) begin
               do_fresh   = 1'b1;
               res_handle = HW'(fresh);
               live_next  = live_q + 1'b1;
            end else begin
               err = ERR_EXHAUSTED;
            end
         end else begin
            res_handle = free_handle;
            if ({1'b0, free_handle} >= NARR_H) begin
               err = ERR_BAD_HANDLE;
            end else if (!in_use[free_handle[IW-1:0]]) begin
               err = ERR_DOUBLE_FREE;
            end else begin
               do_push   = 1'b1;
               live_next = live_q - 1'b1;
            end
         end
      end
   end

   assign success = do_pop | do_fresh | do_push;

   always_ff @(posedge clock) begin
      if (reset) begin
         stack_top    <= '0;
         fresh        <= '0;
         in_use       <= '0;
         rr_ptr       <= '0;
         ack_q        <= '0;
         ack_handle_q <= '0;
         ack_err_q    <= 1'b0;
         clr_valid_q  <= 1'b0;
         clr_handle_q <= '0;
         live_q       <= '0;
         high_q       <= '0;
      end else begin
         ack_q        <= grant;
         ack_handle_q <= res_handle;
         ack_err_q    <= (err != ERR_NONE);
         clr_valid_q  <= success;
         clr_handle_q <= success ? res_handle : '0;
         live_q       <= live_next;
         high_q       <= (live_next > high_q) ? live_next : high_q;
         if (win_valid) begin
            rr_ptr <= (win == LAST_REQ) ? '0 : win + 1'b1;
         end
         if (do_pop) begin
            stack_top <= stack_top - 1'b1;
         end
         if (do_fresh) begin
            fresh <= fresh + 1'b1;
         end
         if (do_pop || do_fresh) begin
            in_use[res_handle[IW-1:0]] <= 1'b1;
         end
         if (do_push) begin
            stack_top                   <= stack_top + 1'b1;
            in_use[free_handle[IW-1:0]] <= 1'b0;
         end
      end
   end

   // Stack storage needs no reset; only entries below stack_top are ever read.
   always_ff @(posedge clock) begin
      if (!reset && do_push) begin
         stack_mem[IW'(stack_top)] <= free_handle;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.ack_handle = ack_handle_q;
   assign bus.ack_err    = ack_err_q;
   assign bus.clr_valid  = clr_valid_q;
   assign bus.clr_handle = clr_handle_q;
   assign bus.live_count = live_q;
   assign bus.high_water = high_q;

endmodule
